sdram_init_seq: RTL and testbench

// - JEDEC SDRAM power-up sequencer. Sits directly downstream of the system reset generator.
// - Its reset input is the inverted delayed system reset (rst = ~sys_rst_n).
// - Once reset is released it performs, in order: power-up wait, PRECHARGE ALL,
//   REF_COUNT AUTO REFRESH commands, LOAD MODE REGISTER.
// - It then raises init_done, which hands the SDRAM command bus to the read/write controller.

---
 rtl/sdram_init_seq.sv | 129 ++++++++++++
 tb/tb_sdram_init_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_init_seq.sv
// rtl/sdram_init_seq.sv - JEDEC SDRAM power-up command sequencer
// Drives power-up wait, PRECHARGE ALL, AUTO REFRESH burst and LOAD MODE, then raises init_done.
module sdram_init_seq #(
    parameter int          T_PWRUP   = 20000,
    parameter int          T_RP      = 2,
    parameter int          T_RFC     = 7,
    parameter int          T_MRD     = 2,
    parameter int          REF_COUNT = 8,
    parameter int          ADDR_W    = 13,
    parameter int          BA_W      = 2,
    parameter logic [12:0] MODE_REG  = 13'h032
) (
    input  logic              clk,
    input  logic              rst,
    output logic              cke,
    output logic              cs_n,
    output logic              ras_n,
    output logic              cas_n,
    output logic              we_n,
    output logic [BA_W-1:0]   ba,
    output logic [ADDR_W-1:0] addr,
    output logic              init_done
);

    localparam int T_MAX1 = (T_PWRUP > T_RP) ? T_PWRUP : T_RP;
    localparam int T_MAX2 = (T_RFC > T_MRD) ? T_RFC : T_MRD;
    localparam int T_MAX  = (T_MAX1 > T_MAX2) ? T_MAX1 : T_MAX2;
    localparam int CW     = $clog2(T_MAX) + 1;
    localparam int RW     = $clog2(REF_COUNT) + 1;

    // Outputs are registered from the current state, so each wait state lasts
    // spacing-1 cycles; a spacing of 1 skips its wait state entirely.
    localparam logic [CW-1:0] PWR_LAST = CW'(T_PWRUP - 1);
    localparam logic [CW-1:0] RP_LAST  = CW'((T_RP  > 1) ? T_RP  - 2 : 0);
    localparam logic [CW-1:0] RFC_LAST = CW'((T_RFC > 1) ? T_RFC - 2 : 0);
    localparam logic [CW-1:0] MRD_LAST = CW'((T_MRD > 1) ? T_MRD - 2 : 0);
    localparam logic [RW-1:0] REF_N    = RW'(REF_COUNT);

    localparam logic [ADDR_W-1:0] ADDR_ALL_BANKS = ADDR_W'(11'h400);
    localparam logic [ADDR_W-1:0] ADDR_MODE      = ADDR_W'(MODE_REG);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_REF  = 4'b0001;
    localparam logic [3:0] CMD_LMR  = 4'b0000;

    localparam logic [2:0] WAIT_PWR = 3'd0;
    localparam logic [2:0] PRECH    = 3'd1;
    localparam logic [2:0] WAIT_RP  = 3'd2;
    localparam logic [2:0] REF      = 3'd3;
    localparam logic [2:0] WAIT_RFC = 3'd4;
    localparam logic [2:0] LMR      = 3'd5;
    localparam logic [2:0] WAIT_MRD = 3'd6;
    localparam logic [2:0] DONE     = 3'd7;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [CW-1:0]     cnt;
    logic [RW-1:0]     ref_cnt;
    logic [RW-1:0]     ref_inc;
    logic [3:0]        cmd;
    logic [3:0]        cmd_d;
    logic [ADDR_W-1:0] addr_d;
    logic              in_wait;

    assign ref_inc = ref_cnt + 1'b1;
    assign in_wait = (state == WAIT_PWR) || (state == WAIT_RP) ||
                     (state == WAIT_RFC) || (state == WAIT_MRD);

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_PWR: if (cnt == PWR_LAST) state_nxt = PRECH;
            PRECH:    state_nxt = (T_RP == 1) ? REF : WAIT_RP;
            WAIT_RP:  if (cnt == RP_LAST) state_nxt = REF;
            REF: begin
                if (T_RFC == 1) state_nxt = (ref_inc < REF_N) ? REF : LMR;
                else            state_nxt = WAIT_RFC;
            end
            WAIT_RFC: if (cnt == RFC_LAST) state_nxt = (ref_cnt < REF_N) ? REF : LMR;
            LMR:      state_nxt = (T_MRD == 1) ? DONE : WAIT_MRD;
            WAIT_MRD: if (cnt == MRD_LAST) state_nxt = DONE;
            default:  state_nxt = state;
        endcase
    end

    always_comb begin
        cmd_d  = CMD_NOP;
        addr_d = '0;
        case (state)
            PRECH: begin
                cmd_d  = CMD_PRE;
                addr_d = ADDR_ALL_BANKS;
            end
            REF:   cmd_d = CMD_REF;
            LMR: begin
                cmd_d  = CMD_LMR;
                addr_d = ADDR_MODE;
            end
            default: cmd_d = CMD_NOP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= WAIT_PWR;
            cnt       <= '0;
            ref_cnt   <= '0;
            cke       <= 1'b0;
            cmd       <= CMD_NOP;
            ba        <= '0;
            addr      <= '0;
            init_done <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) cnt <= '0;
            else if (in_wait)       cnt <= cnt + 1'b1;
            if (state == REF) ref_cnt <= ref_inc;
            cke       <= 1'b1;
            cmd       <= cmd_d;
            ba        <= '0;
            addr      <= addr_d;
            init_done <= (state == DONE);
        end
    end

    assign {cs_n, ras_n, cas_n, we_n} = cmd;

endmodule

// File: tb/tb_sdram_init_seq.sv
// tb/tb_sdram_init_seq.sv - scoreboard bench for sdram_init_seq
module tb_sdram_init_seq;

    localparam logic [3:0] NOP     = 4'b0111;
    localparam logic [3:0] PRE     = 4'b0010;
    localparam logic [3:0] REFC    = 4'b0001;
    localparam logic [3:0] LMRC    = 4'b0000;
    localparam logic [3:0] DONE_EV = 4'b1111;

    typedef struct packed {
        int          cyc;
        logic [3:0]  cmd;
        logic [12:0] addr;
        logic [1:0]  ba;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc   = -1;
    int  sel   = 0;
    logic prev_done = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
    logic cke0, cs_n0, ras_n0, cas_n0, we_n0, done0;
    logic cke1, cs_n1, ras_n1, cas_n1, we_n1, done1;
    logic cke2, cs_n2, ras_n2, cas_n2, we_n2, done2;
    logic [1:0]  ba0, ba1, ba2;
    logic [12:0] addr0, addr1, addr2;

    sdram_init_seq #(.T_PWRUP(10), .T_RP(2), .T_RFC(3), .T_MRD(2), .REF_COUNT(2)) dut_small (
        .clk(clk), .rst(rst0), .cke(cke0), .cs_n(cs_n0), .ras_n(ras_n0), .cas_n(cas_n0),
        .we_n(we_n0), .ba(ba0), .addr(addr0), .init_done(done0));

    sdram_init_seq #(.T_PWRUP(10), .T_RP(1), .T_RFC(1), .T_MRD(1), .REF_COUNT(1)) dut_ones (
        .clk(clk), .rst(rst1), .cke(cke1), .cs_n(cs_n1), .ras_n(ras_n1), .cas_n(cas_n1),
        .we_n(we_n1), .ba(ba1), .addr(addr1), .init_done(done1));

    sdram_init_seq dut_def (
        .clk(clk), .rst(rst2), .cke(cke2), .cs_n(cs_n2), .ras_n(ras_n2), .cas_n(cas_n2),
        .we_n(we_n2), .ba(ba2), .addr(addr2), .init_done(done2));

    logic [3:0]  cmd0, cmd1, cmd2, cmd_m;
    logic        rst_m, cke_m, done_m;
    logic [1:0]  ba_m;
    logic [12:0] addr_m;

    assign cmd0 = {cs_n0, ras_n0, cas_n0, we_n0};
    assign cmd1 = {cs_n1, ras_n1, cas_n1, we_n1};
    assign cmd2 = {cs_n2, ras_n2, cas_n2, we_n2};

    always_comb begin
        rst_m = rst0; cke_m = cke0; cmd_m = cmd0; ba_m = ba0; addr_m = addr0; done_m = done0;
        if (sel == 1) begin
            rst_m = rst1; cke_m = cke1; cmd_m = cmd1; ba_m = ba1; addr_m = addr1; done_m = done1;
        end else if (sel == 2) begin
            rst_m = rst2; cke_m = cke2; cmd_m = cmd2; ba_m = ba2; addr_m = addr2; done_m = done2;
        end
    end

    // Selected-DUT monitor: pops the scoreboard on every command and init_done rise
    always @(negedge clk) begin
        ev_t act;
        ev_t e;
        if (rst_m) begin
            cyc = -1;
            prev_done = 1'b0;
            tests++;
            assert ({cke_m, cmd_m, done_m, ba_m, addr_m} === {1'b0, NOP, 1'b0, 2'b0, 13'h0})
            else begin
                fails++;
                $error("FAIL rst_hold obs=%h exp=%h", {cke_m, cmd_m, done_m, ba_m, addr_m},
                       {1'b0, NOP, 1'b0, 2'b0, 13'h0});
            end
        end else begin
            cyc++;
            tests++;
            assert (cke_m === 1'b1)
            else begin fails++; $error("FAIL cke_high cyc=%0d obs=%b exp=1", cyc, cke_m); end
            if (cmd_m !== NOP) begin
                act.cyc = cyc; act.cmd = cmd_m; act.addr = addr_m; act.ba = ba_m;
                tests++;
                assert (exp_q.size() != 0)
                else begin fails++; $error("FAIL unexpected_cmd cyc=%0d obs=%b exp=none", cyc, cmd_m); end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    tests++;
                    assert (act === e)
                    else begin
                        fails++;
                        $error("FAIL cmd_event obs=cyc%0d/%b/%h/%h exp=cyc%0d/%b/%h/%h",
                               act.cyc, act.cmd, act.addr, act.ba, e.cyc, e.cmd, e.addr, e.ba);
                    end
                end
            end else begin
                tests++;
                assert ({ba_m, addr_m} === 15'h0)
                else begin fails++; $error("FAIL nop_bus cyc=%0d obs=%h exp=0", cyc, {ba_m, addr_m}); end
            end
            if (done_m && !prev_done) begin
                act.cyc = cyc; act.cmd = DONE_EV; act.addr = '0; act.ba = '0;
                tests++;
                assert (exp_q.size() != 0)
                else begin fails++; $error("FAIL unexpected_done cyc=%0d obs=1 exp=0", cyc); end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    tests++;
                    assert (act === e)
                    else begin
                        fails++;
                        $error("FAIL done_event obs=cyc%0d/%b exp=cyc%0d/%b", act.cyc, act.cmd, e.cyc, e.cmd);
                    end
                end
            end
            tests++;
            assert (!(prev_done && !done_m))
            else begin fails++; $error("FAIL done_monotonic cyc=%0d obs=%b exp=1", cyc, done_m); end
            prev_done = done_m;
        end
    end

    // All DUTs: no command while the clock enable is low, and only legal codes
    always @(negedge clk) begin
        tests++;
        assert ((cke0 || cmd0 === NOP) && (cke1 || cmd1 === NOP) && (cke2 || cmd2 === NOP))
        else begin fails++; $error("FAIL cmd_without_cke obs=%b/%b/%b exp=%b", cmd0, cmd1, cmd2, NOP); end
        tests++;
        assert (cmd0 inside {NOP, PRE, REFC, LMRC} && cmd1 inside {NOP, PRE, REFC, LMRC} &&
                cmd2 inside {NOP, PRE, REFC, LMRC})
        else begin fails++; $error("FAIL legal_cmd obs=%b/%b/%b exp=legal", cmd0, cmd1, cmd2); end
    end

    task automatic push_seq(input int tpw, input int trp, input int trfc, input int nref, input int tmrd);
        ev_t e;
        int  l;
        e.cyc = tpw; e.cmd = PRE; e.addr = 13'h400; e.ba = 2'b0;
        exp_q.push_back(e);
        for (int i = 0; i < nref; i++) begin
            e.cyc = tpw + trp + i * trfc; e.cmd = REFC; e.addr = 13'h0;
            exp_q.push_back(e);
        end
        l = tpw + trp + nref * trfc;
        e.cyc = l; e.cmd = LMRC; e.addr = 13'h032;
        exp_q.push_back(e);
        e.cyc = l + tmrd; e.cmd = DONE_EV; e.addr = 13'h0;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done_m; i++) begin
            @(negedge clk); #1;
        end
        tests++;
        assert (done_m === 1'b1)
        else begin fails++; $error("FAIL done_timeout obs=%b exp=1", done_m); end
        repeat (3) begin @(negedge clk); #1; end
        tests++;
        assert (exp_q.size() == 0)
        else begin fails++; $error("FAIL events_left obs=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        tests++;
        assert ({cke0, cmd0, done0, ba0, addr0, cke1, cmd1, done1, cke2, cmd2, done2} ===
                {1'b0, NOP, 1'b0, 2'b0, 13'h0, 1'b0, NOP, 1'b0, 1'b0, NOP, 1'b0})
        else begin fails++; $error("FAIL reset_values obs=%b/%b/%b exp=0/%b/0", cke0, cmd0, done0, NOP); end

        // Small parameters, full sequence
        sel = 0;
        push_seq(10, 2, 3, 2, 2);
        @(negedge clk); #2 rst0 = 1'b0;
        wait_done(100);

        // Reset pulsed between the two refreshes, then a clean rerun
        @(negedge clk); #2 rst0 = 1'b1;
        repeat (2) @(negedge clk);
        push_seq(10, 2, 3, 2, 2);
        @(negedge clk); #2 rst0 = 1'b0;
        for (int i = 0; i < 100 && cyc != 14; i++) begin
            @(negedge clk); #1;
        end
        tests++;
        assert (cyc == 14)
        else begin fails++; $error("FAIL reach_cycle14 obs=%0d exp=14", cyc); end
        #2 rst0 = 1'b1;
        #1;
        tests++;
        assert ({cke0, cmd0, done0, ba0, addr0} === {1'b0, NOP, 1'b0, 2'b0, 13'h0})
        else begin fails++; $error("FAIL async_clear obs=%h exp=%h", {cke0, cmd0, done0, ba0, addr0},
                                   {1'b0, NOP, 1'b0, 2'b0, 13'h0}); end
        tests++;
        assert (exp_q.size() == 3)
        else begin fails++; $error("FAIL events_before_pulse obs=%0d exp=3", exp_q.size()); end
        exp_q.delete();
        repeat (3) @(negedge clk);
        push_seq(10, 2, 3, 2, 2);
        @(negedge clk); #2 rst0 = 1'b0;
        wait_done(100);

        // Unit spacings and a single refresh
        @(negedge clk); #2 rst0 = 1'b1;
        sel = 1;
        repeat (2) @(negedge clk);
        push_seq(10, 1, 1, 1, 1);
        @(negedge clk); #2 rst1 = 1'b0;
        wait_done(100);

        // Default parameters, then a long quiet tail
        @(negedge clk); #2 rst1 = 1'b1;
        sel = 2;
        repeat (2) @(negedge clk);
        push_seq(20000, 2, 7, 8, 2);
        @(negedge clk); #2 rst2 = 1'b0;
        wait_done(21000);
        repeat (1000) begin @(negedge clk); #1; end
        tests++;
        assert (done_m === 1'b1 && exp_q.size() == 0)
        else begin fails++; $error("FAIL tail_state obs=%b/%0d exp=1/0", done_m, exp_q.size()); end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
